// File: rtl/crp_spi_pkg.sv
// crp_spi_pkg: shared state type and SPI opcodes for the serial SRAM controller.
// Optional feature macro: CRP_SPI_FAST_READ_EN.
package crp_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    DONE
  } state_t;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_WRITE     = 8'h02;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  function automatic int unsigned state_bits(
    input state_t      s,
    input int unsigned addr_w
  );
    case (s)
      CMD, DUMMY, DATA: return 32'd8;
      ADDR:             return addr_w;
      default:          return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/crp_spi_shifter.sv
// crp_spi_shifter: 8-bit MSB-first shift register for SPI frames.
// Load has priority over shift; sin enters at the LSB.
module crp_spi_shifter
  import crp_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       shift,
  input  logic       sin,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 8'h00;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {q[6:0], sin};
    end
  end

endmodule

// File: rtl/crp_spi_mem_ctrl.sv
// crp_spi_mem_ctrl: single-byte SPI mode-0 controller for 23LC512-class SRAM.
// Define CRP_SPI_FAST_READ_EN for 0x0B reads with 8 dummy bits.
module crp_spi_mem_ctrl
  import crp_spi_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int BW = $clog2(24 + ADDR_W + 8 + 1);
  localparam logic [BW-1:0] ADDR_END =
    BW'(state_bits(CMD, ADDR_W) + state_bits(ADDR, ADDR_W));
  localparam logic [3:0] HALF = 4'(CLK_DIV - 1);
`ifdef CRP_SPI_FAST_READ_EN
  localparam logic [7:0] RD_OP = OP_FAST_READ;
`else
  localparam logic [7:0] RD_OP = OP_READ;
`endif

  state_t            state;
  state_t            nxt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [3:0]        hcnt;
  logic [BW-1:0]     bit_cnt;
  logic [BW-1:0]     nb;
  logic              active;
  logic              accept;
  logic              tick;
  logic              rise;
  logic              fall;
  logic              ld;
  logic              ld_addr;
  logic [7:0]        ld_byte;
  logic [7:0]        sh_q;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign active    = state inside {CMD, ADDR, DUMMY, DATA};
  assign tick      = active && (hcnt == 4'd0);
  assign rise      = tick && !spi_sclk;
  assign fall      = tick && spi_sclk;
  assign nb        = bit_cnt + BW'(1);

  // Byte reloads happen on the SCLK fall that opens a new byte.
  always_comb begin
    nxt     = state;
    ld      = 1'b0;
    ld_addr = 1'b0;
    ld_byte = 8'h00;
    if (accept) begin
      ld      = 1'b1;
      ld_byte = req_we ? OP_WRITE : RD_OP;
    end else if (fall && nb[2:0] == 3'd0) begin
      unique case (state)
        CMD: begin
          nxt     = ADDR;
          ld      = 1'b1;
          ld_addr = 1'b1;
          ld_byte = addr_q[ADDR_W-1 -: 8];
        end
        ADDR: begin
          ld = 1'b1;
          if (nb != ADDR_END) begin
            ld_addr = 1'b1;
            ld_byte = addr_q[ADDR_W-1 -: 8];
          end
`ifdef CRP_SPI_FAST_READ_EN
          else if (!we_q) begin
            nxt = DUMMY;
          end
`endif
          else begin
            nxt     = DATA;
            ld_byte = we_q ? wdata_q : 8'h00;
          end
        end
`ifdef CRP_SPI_FAST_READ_EN
        DUMMY: begin
          nxt = DATA;
          ld  = 1'b1;
        end
`endif
        DATA:    nxt = DONE;
        default: ;
      endcase
    end
  end

  crp_spi_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ld),
    .load_data (ld_byte),
    .shift     (rise),
    .sin       (spi_miso),
    .q         (sh_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      hcnt      <= 4'd0;
      bit_cnt   <= '0;
      spi_cs_n  <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        state    <= CMD;
        we_q     <= req_we;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        hcnt     <= HALF;
        bit_cnt  <= '0;
        spi_cs_n <= 1'b0;
        spi_sclk <= 1'b0;
        spi_mosi <= ld_byte[7];
      end else if (state == DONE) begin
        state <= IDLE;
      end else if (active) begin
        if (!tick) begin
          hcnt <= hcnt - 4'd1;
        end else begin
          hcnt     <= HALF;
          spi_sclk <= !spi_sclk;
          if (fall) begin
            state   <= nxt;
            bit_cnt <= nb;
            if (ld_addr) addr_q <= addr_q << 8;
            if (nxt == DONE) begin
              spi_cs_n  <= 1'b1;
              spi_mosi  <= 1'b0;
              rsp_valid <= 1'b1;
              if (!we_q) rsp_rdata <= sh_q;
            end else begin
              spi_mosi <= ld ? ld_byte[7] : sh_q[7];
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/crp_spi_mem_ctrl.md
Name: crp_spi_mem_ctrl

Overview:
- SPI memory controller between the 8-bit CPU core inside tt_um_rodald_wrapper and an external 23LC512-class serial SRAM on the uio pins.
- Accepts one byte read/write request at a time from the core.
- Runs an SPI mode-0 transaction and returns read data or write completion with a one-cycle response pulse.
- The wrapper maps the spi_* pins onto uio_out/uio_in/uio_oe.

Parameters:
- ADDR_W, 16, address width in bits; must be 16 or 24.
- CLK_DIV, 1, SCLK half-period in clk cycles; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request (high only in IDLE)
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  byte address
- req_wdata  input  8  write data
- rsp_valid  output  1  one-cycle pulse: transaction complete
- rsp_rdata  output  8  read data; valid with rsp_valid on reads, held until the next read completes
- spi_cs_n  output  1  chip select, active low
- spi_sclk  output  1  serial clock, idles low
- spi_mosi  output  1  serial data out, MSB first
- spi_miso  input  1  serial data in

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low, ports named clk and rst_n.
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, rsp_valid=0, rsp_rdata=0x00, state=IDLE. req_ready=1 from the first cycle after reset deasserts.
- Accept: on a rising edge with req_valid && req_ready. req_we, req_addr and req_wdata are latched at that edge; later input changes are ignored.
- States:
  - IDLE -> CMD on accept.
  - CMD: 8 bits. Opcode 0x03 for read, 0x02 for write.
  - ADDR: ADDR_W bits, MSB first.
  - DATA: 8 bits. MOSI = wdata on writes; MOSI = 0 on reads.
  - DONE: 1 cycle, then IDLE.
- Bit timing:
  - Each bit is a low half of CLK_DIV cycles (SCLK=0, MOSI updated at its first edge) followed by a high half of CLK_DIV cycles (SCLK=1).
  - MISO is sampled into the shift register at the edge that raises SCLK.
  - spi_cs_n goes low at the accepting edge and returns high at the edge entering DONE.
  - SCLK is 0 in IDLE and DONE.
- Transaction length: NB = 16 + ADDR_W bits. State is DONE after exactly 2·CLK_DIV·NB edges counted from the accepting edge. At the defaults, rsp_valid is high in the 65th cycle after accept.
- Response: rsp_valid is high only in the DONE cycle, for both reads and writes. rsp_rdata updates at DONE entry for reads only; writes leave it unchanged.
- Chip-select gap: minimum spi_cs_n high time between transactions is 2 cycles (DONE + IDLE). Back-to-back requests are accepted in the IDLE cycle following DONE.
- Reset mid-transaction: at the next edge with rst_n=0, all outputs take their reset values (cs_n high immediately). No rsp_valid is issued. The aborted transaction is lost.
- Counters: the bit counter is sized for NB+8. The half-period counter is 4 bits, reloaded each half. No wrap-around beyond DATA.
- req_valid asserted outside IDLE: ignored; no queuing.

Optional Feature:
- Macro: CRP_SPI_FAST_READ_EN.
- Defined: reads use opcode 0x0B with 8 dummy bits (MOSI=0, MISO ignored) between ADDR and DATA. Read NB = 24 + ADDR_W; read latency at defaults is 80 edges + DONE. Writes are unchanged.
- Undefined: opcode 0x03 and no dummy state; the dummy state and its logic are absent.

Decomposition:
- Package crp_spi_pkg:
  - state enum (IDLE, CMD, ADDR, DUMMY, DATA, DONE)
  - opcode localparams OP_READ=0x03, OP_WRITE=0x02, OP_FAST_READ=0x0B
  - helper constant for the bit count per state
- One sub-module, crp_spi_shifter: 8-bit bidirectional MSB-first shift register with load, shift-out and sample-in controls. The FSM, SCLK divider and counters stay in crp_spi_mem_ctrl.

Test Plan:
- Reset hold 3 cycles, release -> cs_n=1, sclk=0, req_ready=1, rsp_valid=0, rsp_rdata=0x00.
- Write addr 0x1234 data 0xA5 (defaults) -> MOSI bitstream 0x02,0x12,0x34,0xA5; 32 SCLK rising edges; rsp_valid pulse 64 edges after accept; rsp_rdata unchanged.
- Read addr 0x00FF with SPI model returning 0x3C -> MOSI 0x03,0x00,0xFF,0x00; rsp_rdata=0x3C with rsp_valid; value held through a following write.
- CLK_DIV=3, read -> SCLK high/low halves of 3 cycles each; rsp_valid after 192 edges; req_ready low throughout.
- Back-to-back: req_valid held high for two requests -> second accept in the IDLE cycle after DONE; cs_n high exactly 2 cycles between frames.
- rst_n low at bit 10 of a read -> cs_n=1 at the next edge, no rsp_valid; a subsequent read of 0x0001 completes normally. With CRP_SPI_FAST_READ_EN defined: opcode 0x0B, 8 dummy bits, rsp_valid after 80 edges.
